// File: rtl/sram_1rw1r_pipe_if.sv
// Bus bundle for sram_1rw1r_pipe: port 0 (RW, byte mask), port 1 (R), status.
interface sram_1rw1r_pipe_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8
);
   localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8;

   logic                  ready_o;
   logic                  csb0_i;
   logic                  web0_i;
   logic [NUM_WMASKS-1:0] wmask0_i;
   logic [ADDR_WIDTH-1:0] addr0_i;
   logic [DATA_WIDTH-1:0] din0_i;
   logic [DATA_WIDTH-1:0] dout0_o;
   logic                  rvalid0_o;
   logic                  csb1_i;
   logic [ADDR_WIDTH-1:0] addr1_i;
   logic [DATA_WIDTH-1:0] dout1_o;
   logic                  rvalid1_o;
   logic                  collision_o;

   // Requester side
   modport master (
      input  ready_o, dout0_o, rvalid0_o, dout1_o, rvalid1_o, collision_o,
      output csb0_i, web0_i, wmask0_i, addr0_i, din0_i, csb1_i, addr1_i
   );

   // Memory side
   modport slave (
      output ready_o, dout0_o, rvalid0_o, dout1_o, rvalid1_o, collision_o,
      input  csb0_i, web0_i, wmask0_i, addr0_i, din0_i, csb1_i, addr1_i
   );
endinterface

// File: rtl/sram_1rw1r_pipe.sv
// 1RW1R SRAM model with configurable read latency, post-reset clear and
// same-address write/read forwarding.
module sram_1rw1r_pipe #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned NUM_WMASKS     = DATA_WIDTH / 8,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned BYPASS         = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   sram_1rw1r_pipe_if.slave    bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_INIT,
      ST_RUN
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  init_we_c;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wr0_c, rd0_c, rd1_c, col_c;
   logic [DATA_WIDTH-1:0] old0_c, old1_c, merged_c, rdata1_c;

   logic                  s1_vld0_q, s1_vld1_q, s1_col_q;
   logic [DATA_WIDTH-1:0] s1_dat0_q, s1_dat1_q;

   // Next-state logic: leave reset, sweep the array with zeros, then run
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      init_we_c = 1'b0;
      case (state_q)
         ST_RESET: begin
            cnt_d   = '0;
            state_d = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
         end
         ST_INIT: begin
            init_we_c = 1'b1;
            cnt_d     = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
      ready_d = (state_d == ST_RUN);
   end

   // State, clear counter and ready flag
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // Request decode; old words are the array contents before this edge
   always_comb begin
      rd0_c    = ready_q & ~bus.csb0_i & bus.web0_i;
      wr0_c    = ready_q & ~bus.csb0_i & ~bus.web0_i;
      rd1_c    = ready_q & ~bus.csb1_i;
      col_c    = wr0_c & rd1_c & (bus.addr0_i == bus.addr1_i);
      old0_c   = mem_q[bus.addr0_i];
      old1_c   = mem_q[bus.addr1_i];
      merged_c = old1_c;
      for (int k = 0; k < int'(NUM_WMASKS); k++) begin
         if (bus.wmask0_i[k]) begin
            merged_c[8*k +: 8] = bus.din0_i[8*k +: 8];
         end
      end
      rdata1_c = (BYPASS != 0 && col_c) ? merged_c : old1_c;
   end

   // Array update: clear sweep during init, masked port 0 writes when running
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if (init_we_c) begin
            mem_q[cnt_q] <= '0;
         end else if (wr0_c) begin
            for (int k = 0; k < int'(NUM_WMASKS); k++) begin
               if (bus.wmask0_i[k]) begin
                  mem_q[bus.addr0_i][8*k +: 8] <= bus.din0_i[8*k +: 8];
               end
            end
         end
      end
   end

   // First read stage; data registers hold their value when idle
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_vld0_q <= 1'b0;
         s1_vld1_q <= 1'b0;
         s1_col_q  <= 1'b0;
         s1_dat0_q <= '0;
         s1_dat1_q <= '0;
      end else begin
         s1_vld0_q <= rd0_c;
         s1_vld1_q <= rd1_c;
         s1_col_q  <= col_c;
         if (rd0_c) begin
            s1_dat0_q <= old0_c;
         end
         if (rd1_c) begin
            s1_dat1_q <= rdata1_c;
         end
      end
   end

   assign bus.ready_o = ready_q;

   if (READ_LATENCY == 1) begin : g_lat1
      assign bus.dout0_o     = s1_dat0_q;
      assign bus.rvalid0_o   = s1_vld0_q;
      assign bus.dout1_o     = s1_dat1_q;
      assign bus.rvalid1_o   = s1_vld1_q;
      assign bus.collision_o = s1_col_q;
   end else begin : g_lat2
      logic                  out_vld0_q, out_vld1_q, out_col_q;
      logic [DATA_WIDTH-1:0] out_dat0_q, out_dat1_q;

      // Extra output stage for the two-cycle latency configuration
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            out_vld0_q <= 1'b0;
            out_vld1_q <= 1'b0;
            out_col_q  <= 1'b0;
            out_dat0_q <= '0;
            out_dat1_q <= '0;
         end else begin
            out_vld0_q <= s1_vld0_q;
            out_vld1_q <= s1_vld1_q;
            out_col_q  <= s1_col_q;
            if (s1_vld0_q) begin
               out_dat0_q <= s1_dat0_q;
            end
            if (s1_vld1_q) begin
               out_dat1_q <= s1_dat1_q;
            end
         end
      end

      assign bus.dout0_o     = out_dat0_q;
      assign bus.rvalid0_o   = out_vld0_q;
      assign bus.dout1_o     = out_dat1_q;
      assign bus.rvalid1_o   = out_vld1_q;
      assign bus.collision_o = out_col_q;
   end
endmodule

// File: doc/sram_1rw1r_pipe.md
Name: sram_1rw1r_pipe

Overview:
- Parametrised, synthesizable-behaviour successor to the team's 1RW1R OpenRAM macro model.
- Single clock domain. Port 0 is read/write with a byte write mask; port 1 is read-only.
- Adds over the previous model:
  - configurable read latency (1 or 2), with read-valid strobes
  - optional hardware clear of the array after reset, with a ready flag
  - selectable same-address write/read forwarding, with a collision strobe
- Sits between the instruction/data bus adapters and the memory array in the SoC memory subsystem.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words.
- NUM_WMASKS, DATA_WIDTH/8, byte-lane count (derived; do not override).
- READ_LATENCY, 1, cycles from accepted read to data/valid; legal values 1 or 2.
- BYPASS, 1, 1 = port 1 sees same-cycle port 0 write data; 0 = port 1 sees old data.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting requests.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_ni  in  1  synchronous active-low reset.
- ready_o  out  1  high when requests are accepted.
- csb0_i  in  1  port 0 active-low select.
- web0_i  in  1  port 0 active-low write enable.
- wmask0_i  in  NUM_WMASKS  port 0 byte write mask; bit k enables byte k.
- addr0_i  in  ADDR_WIDTH  port 0 address.
- din0_i  in  DATA_WIDTH  port 0 write data.
- dout0_o  out  DATA_WIDTH  port 0 read data.
- rvalid0_o  out  1  port 0 read data valid, one-cycle pulse.
- csb1_i  in  1  port 1 active-low select.
- addr1_i  in  ADDR_WIDTH  port 1 address.
- dout1_o  out  DATA_WIDTH  port 1 read data.
- rvalid1_o  out  1  port 1 read data valid, one-cycle pulse.
- collision_o  out  1  pulse: port 0 write and port 1 read to the same address in the same cycle.

Behaviour:
- Reset (rst_ni=0 at posedge), reset values:
  - ready_o=0, dout0_o=0, dout1_o=0, rvalid0_o=0, rvalid1_o=0, collision_o=0.
  - All pipeline valid bits cleared; the init counter is set to 0.
  - Array contents are not reset directly.
- State machine: RESET -> INIT -> RUN.
  - RESET: the state while rst_ni=0.
  - INIT (CLEAR_ON_RESET=1):
    - one word per cycle, mem[cnt]=0, cnt = 0..DEPTH-1.
    - After writing DEPTH-1, go to RUN, so ready_o rises DEPTH+1 cycles after the first posedge with rst_ni=1.
  - CLEAR_ON_RESET=0: go directly to RUN; ready_o=1 from the first posedge after reset release.
  - RUN: the normal operating state.
  - Reset asserted in any state aborts work: in-flight reads are dropped (no rvalid) and the clear restarts from address 0.
- Request acceptance:
  - A request is accepted only at a posedge with ready_o=1 and csb active.
  - Requests presented while ready_o=0 are ignored: no write, no rvalid.
- Port 0 write (csb0_i=0, web0_i=0):
  - At the accepting posedge, byte k of mem[addr0_i] <- din0_i byte k if wmask0_i[k]=1; other bytes unchanged.
  - wmask0_i=0 performs no write.
  - A write produces no rvalid0_o and leaves dout0_o unchanged.
- Port 0 read (csb0_i=0, web0_i=1): returns mem[addr0_i] as it was before that edge.
- Port 1 read (csb1_i=0): returns mem[addr1_i].
- Read latency, for a read accepted at edge N:
  - READ_LATENCY=1: dout/rvalid are updated at edge N (visible in cycle N+1).
  - READ_LATENCY=2: one extra output register stage, updated at edge N+1.
- rvalid is a single-cycle pulse per accepted read. Back-to-back reads give back-to-back pulses at full throughput.
- dout holds its last read value when there is no read; it is never driven to X.
- Same-address collision: port 0 write and port 1 read to the same address in the same cycle, both accepted.
  - collision_o pulses aligned with rvalid1_o of that read.
  - BYPASS=1: dout1_o = merged word (masked bytes from din0_i, unmasked bytes from the old memory word).
  - BYPASS=0: dout1_o = old memory word.
  - The array always takes the write.
- Port 0 and port 1 reads to the same address with no write: both return the same data. No collision_o.
- Address wrap: none. Every address is 0..DEPTH-1 and fully decoded.

Test Plan:
- Defaults, CLEAR_ON_RESET=1: hold rst_ni=0 for 3 cycles, then release -> ready_o=0 for 257 cycles, then 1. Port 1 reads of addresses 0x00, 0x7F, 0xFF return 0x00000000.
- Byte mask: write 0xDEADBEEF to 0x10 with mask 4'b1111, then write 0x11223344 to 0x10 with mask 4'b0101, then port 0 read 0x10 -> dout0_o=0xDE22BE44 with a one-cycle rvalid0_o at latency READ_LATENCY; run for both latency values.
- Collision: with 0xAABBCCDD stored at 0x05, port 0 writes 0x11223344 with mask 4'b0011 while port 1 reads 0x05 in the same cycle:
  - BYPASS=1 -> dout1_o=0xAABB3344, collision_o=1.
  - BYPASS=0 -> dout1_o=0xAABBCCDD.
  - In both cases a later read returns 0xAABB3344.
- Throughput: 8 consecutive port 1 reads of addresses 0..7 (preloaded with the value i) at READ_LATENCY=2 -> rvalid1_o high for 8 consecutive cycles starting 2 cycles after the first request, data 0..7 in order.
- Gated requests: issue a write to 0x20 during INIT -> ignored. After ready_o=1, a read of 0x20 returns 0.
- Mid-operation reset: assert rst_ni=0 for 1 cycle while a READ_LATENCY=2 read is in flight -> no rvalid pulse; ready_o=0, and the clear restarts from address 0.
